// File: rtl/button_debouncer_if.sv
// ============================================================================
//  Module      : button_debouncer_if
//  Description : Pad-side and conditioned button signals of button_debouncer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface button_debouncer_if #(
    parameter int NUM_CH = 7
);
    logic [NUM_CH-1:0] btn_raw_i;
    logic [NUM_CH-1:0] btn_o;
    logic [NUM_CH-1:0] press_o;
    logic [NUM_CH-1:0] release_o;
    logic [NUM_CH-1:0] hold_o;

    modport master (
        output btn_raw_i,
        input  btn_o,
        input  press_o,
        input  release_o,
        input  hold_o
    );

    modport slave (
        input  btn_raw_i,
        output btn_o,
        output press_o,
        output release_o,
        output hold_o
    );
endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
//  Module      : button_debouncer
//  Description : Per-channel synchroniser, polarity fix, debounce filter,
//                press/release pulses and long-press hold flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int                NUM_CH          = 7,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 250000,
    parameter int                HOLD_CYCLES     = 25000000,
    parameter logic [NUM_CH-1:0] INVERT_MASK     = NUM_CH'(1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    button_debouncer_if.slave   bus
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] btn_vec;
    logic [NUM_CH-1:0] press_vec;
    logic [NUM_CH-1:0] release_vec;
    logic [NUM_CH-1:0] hold_vec;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [DEB_W-1:0]       cnt_q, cnt_d;
            logic                   btn_q, btn_d;
            logic                   press_q, press_d;
            logic                   release_q, release_d;
            logic                   s;

            // Preloading the inactive pad level keeps s at 0 out of reset.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn_raw_i[i]};
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    sync_q <= {SYNC_STAGES{INVERT_MASK[i]}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC_STAGES-1] ^ INVERT_MASK[i];

            always_comb begin
                cnt_d     = cnt_q;
                btn_d     = btn_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                if (s == btn_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    btn_d     = s;
                    cnt_d     = '0;
                    press_d   = s;
                    release_d = ~s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q     <= '0;
                    btn_q     <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    cnt_q     <= cnt_d;
                    btn_q     <= btn_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                end
            end

            if (HOLD_CYCLES > 0) begin : g_hold
                localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
                localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

                logic [HOLD_W-1:0] hcnt_q, hcnt_d;
                logic              hold_q, hold_d;

                // Counting only once btn_q is already high places the flag
                // exactly HOLD_CYCLES after the press pulse; clearing on btn_d
                // drops it together with the release pulse.
                always_comb begin
                    hcnt_d = hcnt_q;
                    if (!btn_d) begin
                        hcnt_d = '0;
                    end else if (btn_q && (hcnt_q != HOLD_MAX)) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    hold_d = (hcnt_d == HOLD_MAX);
                end

                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        hcnt_q <= '0;
                        hold_q <= 1'b0;
                    end else begin
                        hcnt_q <= hcnt_d;
                        hold_q <= hold_d;
                    end
                end

                assign hold_vec[i] = hold_q;
            end else begin : g_no_hold
                assign hold_vec[i] = 1'b0;
            end

            assign btn_vec[i]     = btn_q;
            assign press_vec[i]   = press_q;
            assign release_vec[i] = release_q;
        end
    endgenerate

    assign bus.btn_o     = btn_vec;
    assign bus.press_o   = press_vec;
    assign bus.release_o = release_vec;
    assign bus.hold_o    = hold_vec;

endmodule

`default_nettype wire
